// File: rtl/bcd_time_counter_pkg.sv
// Shared digit limits, the BCD time record and helpers for the time-of-day counter.
package bcd_time_counter_pkg;

  localparam int          NUM_DIGITS     = 6;
  localparam logic [3:0]  SEC_TENS_MAX   = 4'd5;
  localparam logic [3:0]  HOUR_TENS_MAX  = 4'd2;
  localparam logic [7:0]  HOUR_MAX       = 8'h23;
  localparam logic [7:0]  H12_NOON       = 8'h12;

  // Index 0 = seconds units ... 5 = hour tens
  localparam logic [NUM_DIGITS-1:0][3:0] DIGIT_MAX =
    {HOUR_TENS_MAX, 4'd9, SEC_TENS_MAX, 4'd9, SEC_TENS_MAX, 4'd9};

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } bcd_time_t;

  function automatic logic bcd_time_valid(input logic [23:0] t);
    return (t[3:0] <= 4'd9) && (t[7:4] <= SEC_TENS_MAX) &&
           (t[11:8] <= 4'd9) && (t[15:12] <= SEC_TENS_MAX) &&
           (t[19:16] <= 4'd9) && (t[23:20] <= 4'd9) &&
           (t[23:16] <= HOUR_MAX);
  endfunction

  function automatic logic [7:0] hour_to_12h(input logic [7:0] hh);
    logic [4:0] dec;
    dec = 5'(hh[7:4] * 10 + hh[3:0]);
    if (dec == 5'd0) return H12_NOON;
    if (dec > 5'd12) dec = dec - 5'd12;
    return {3'b000, dec >= 5'd10, (dec >= 5'd10) ? 4'(dec - 5'd10) : dec[3:0]};
  endfunction

endpackage

// File: rtl/bcd_time_counter_digit.sv
// One BCD digit: wraps at MAX, terminal count flags the carry into the next digit.
module bcd_digit #(
  parameter logic [3:0] MAX  = 4'd9,
  parameter logic [3:0] INIT = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       en,
  output logic [3:0] q,
  output logic [3:0] d,
  output logic       tc
);

  assign tc = en && (q == MAX);

  // d is exposed so the top can compare against the post-advance value
  always_comb begin
    d = q;
    if (ld)       d = ld_val;
    else if (clr) d = '0;
    else if (en)  d = (q == MAX) ? 4'd0 : q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) q <= INIT;
    else     q <= d;
  end

endmodule

// File: rtl/bcd_time_counter.sv
// hh:mm:ss BCD time-of-day counter: prescaler, six-digit cascade, validated load,
// 12h display view and alarm compare.
module bcd_time_counter
  import bcd_time_counter_pkg::*;
#(
  parameter int          TICKS_PER_SEC = 10,
  parameter logic [23:0] INIT_TIME     = 24'h000000,
  parameter bit          ALARM_PULSE   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_en,
  input  logic        run,
  input  logic        load,
  input  logic [23:0] load_time,
  input  logic        mode_12h,
  input  logic        alarm_en,
  input  logic [23:0] alarm_time,
  input  logic        alarm_ack,
  output logic [23:0] time_bcd,
  output logic        pm,
  output logic        sec_pulse,
  output logic        day_wrap,
  output logic        alarm_hit,
  output logic        load_err
);

  localparam int            PW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0]                 presc;
  logic [NUM_DIGITS-1:0][3:0]    cur, nxt;
  logic [NUM_DIGITS-1:0]         en, tc;
  logic                          load_ok, adv, hour_wrap, alarm_match;
  logic                          unused_tc;
  bcd_time_t                     cur_t;
  logic [7:0]                    hh_disp;

  assign load_ok   = load && bcd_time_valid(load_time);
  // Any load request, even a rejected one, takes the cycle and suppresses the tick
  assign adv       = run && tick_en && (presc == PRE_LAST) && !load;
  assign en        = {tc[NUM_DIGITS-2:0], adv};
  assign hour_wrap = tc[3] && (cur[5:4] == HOUR_MAX);
  assign unused_tc = tc[NUM_DIGITS-1];

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit #(
      .MAX  (DIGIT_MAX[i]),
      .INIT (INIT_TIME[4*i +: 4])
    ) u_digit (
      .clk    (clk),
      .rst    (rst),
      .clr    ((i >= 4) ? hour_wrap : 1'b0),
      .ld     (load_ok),
      .ld_val (load_time[4*i +: 4]),
      .en     (en[i]),
      .q      (cur[i]),
      .d      (nxt[i]),
      .tc     (tc[i])
    );
  end

  assign alarm_match = adv && alarm_en && bcd_time_valid(alarm_time) && (nxt == alarm_time);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      sec_pulse <= 1'b0;
      day_wrap  <= 1'b0;
      alarm_hit <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      if (load) begin
        if (load_ok) presc <= '0;
      end else if (run && tick_en) begin
        presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
      end
      sec_pulse <= adv;
      day_wrap  <= hour_wrap;
      load_err  <= load && !load_ok;
      if (alarm_match)                              alarm_hit <= 1'b1;
      else if (ALARM_PULSE || alarm_ack || !alarm_en) alarm_hit <= 1'b0;
    end
  end

  assign cur_t    = cur;
  assign pm       = cur_t.hh >= H12_NOON;
  assign hh_disp  = mode_12h ? hour_to_12h(cur_t.hh) : cur_t.hh;
  assign time_bcd = {hh_disp, cur_t.mm, cur_t.ss};

endmodule
